serial_adder_ctrl: RTL and testbench

//  Bit-serial adder sequencer. Reuses one 1-bit full-adder cell over WIDTH clock cycles to
//  add two WIDTH-bit operands, LSB first. Carry is held in a flip-flop between cycles.

---
 rtl/serial_pkg.sv | 18 +
 rtl/full_adder.sv | 40 ++++
 rtl/half_adder.sv | 20 ++
 rtl/serial_adder_ctrl.sv | 105 ++++++++++
 tb/tb_serial_adder_ctrl.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_pkg.sv
// rtl/serial_pkg.sv - shared state encoding for the bit-serial adder sequencer
//
// Purpose: state type used by serial_adder_ctrl. Code 2'b11 is never
// produced; the FSM decodes it back to S_IDLE.
// Ports: none (package).

package serial_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - combinational 1-bit full adder from two half adders
//
// Purpose: {C,S} = x + y + z, shared cell reused every RUN cycle.
// Ports:
//   S  out  sum bit
//   C  out  carry-out
//   x  in   operand bit
//   y  in   operand bit
//   z  in   carry-in

module full_adder (
    output logic S,
    output logic C,
    input  logic x,
    input  logic y,
    input  logic z
);

    logic s_mid;
    logic c_lo;
    logic c_hi;

    half_adder u_ha_lo (
        .S (s_mid),
        .C (c_lo),
        .x (x),
        .y (y)
    );

    half_adder u_ha_hi (
        .S (S),
        .C (c_hi),
        .x (s_mid),
        .y (z)
    );

    // Both half-adder carries can never be 1 together, so OR is exact.
    assign C = c_lo | c_hi;

endmodule

// File: rtl/half_adder.sv
// rtl/half_adder.sv - combinational 1-bit half adder
//
// Purpose: S = x ^ y, C = x & y. Building block of full_adder.
// Ports:
//   S  out  sum bit
//   C  out  carry bit
//   x  in   operand bit
//   y  in   operand bit

module half_adder (
    output logic S,
    output logic C,
    input  logic x,
    input  logic y
);

    assign S = x ^ y;
    assign C = x & y;

endmodule

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial adder sequencer (LSB first, one FA cell)
//
// Purpose: adds two WIDTH-bit operands over WIDTH RUN cycles through a single
// full_adder, carry held in a flip-flop. IDLE -> RUN -> DONE -> IDLE.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only in IDLE
//   a, b   in   WIDTH-bit operands, captured on accepted start
//   cin    in   carry-in, captured on accepted start
//   busy   out  high in RUN and DONE
//   done   out  one-cycle pulse, sum/cout valid
//   sum    out  WIDTH-bit result, held until next accepted start
//   cout   out  final carry-out, same hold rule as sum

module serial_adder_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W   = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder u_fa (
        .S (fa_s),
        .C (fa_c),
        .x (a_sr[0]),
        .y (b_sr[0]),
        .z (carry)
    );

    // Control only depends on start/cnt/state, so X operands reach sum alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        sum   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // Result bits enter at the MSB and move down, so after
                    // WIDTH shifts bit 0 holds the first (LSB) sum bit.
                    sum   <= {fa_s, sum[WIDTH-1:1]};
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    carry <= fa_c;
                    if (cnt == CNT_MAX) begin
                        cout  <= fa_c;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - scoreboard bench for serial_adder_ctrl (WIDTH 4 and 8)

module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [3:0] sum;
    logic       cout;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       cin8;
    logic       busy8;
    logic       done8;
    logic [7:0] sum8;
    logic       cout8;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int cyc       = 0;

    logic [4:0] exp_q[$];
    logic [8:0] exp8_q[$];
    int         done_cyc[$];
    logic       prev_done;
    logic [4:0] last_res;
    logic       prev_done8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .busy  (busy8),
        .done  (done8),
        .sum   (sum8),
        .cout  (cout8)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        total_cnt++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endtask

    // Monitor for WIDTH=4: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done === 1'b1) begin
                done_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_done4", 64'd1, 64'd0);
                end else begin
                    last_res <= exp_q[0];
                    check("result4", {cout, sum}, exp_q.pop_front());
                end
                if (prev_done === 1'b1) check("done4_width", 64'd2, 64'd1);
            end else if (prev_done === 1'b1) begin
                check("result4_hold", {cout, sum}, last_res);
            end
            prev_done <= done;
        end else begin
            prev_done <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (done8 === 1'b1) begin
                if (exp8_q.size() == 0) check("unexpected_done8", 64'd1, 64'd0);
                else check("result8", {cout8, sum8}, exp8_q.pop_front());
                if (prev_done8 === 1'b1) check("done8_width", 64'd2, 64'd1);
            end
            prev_done8 <= done8;
        end else begin
            prev_done8 <= 1'b0;
        end
    end

    task automatic wait_idle4();
        int n = 0;
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle4_timeout", 64'd1, 64'd0);
    endtask

    task automatic issue4(input logic [3:0] av, input logic [3:0] bv, input logic cv,
                          input logic [4:0] expv, input bit push);
        wait_idle4();
        a     = av;
        b     = bv;
        cin   = cv;
        start = 1'b1;
        if (push) exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                          input logic [8:0] expv);
        int n = 0;
        while (busy8 !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle8_timeout", 64'd1, 64'd0);
        a8     = av;
        b8     = bv;
        cin8   = cv;
        start8 = 1'b1;
        exp8_q.push_back(expv);
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || exp8_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n >= 200), 64'd0);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [8:0] r;
    } vec8_t;

    vec8_t v8[8] = '{
        '{8'hFF, 8'h01, 1'b0, 9'h100},
        '{8'h80, 8'h80, 1'b1, 9'h101},
        '{8'hA5, 8'h5A, 1'b0, 9'h0FF},
        '{8'hA5, 8'h5A, 1'b1, 9'h100},
        '{8'h00, 8'h00, 1'b0, 9'h000},
        '{8'h7F, 8'h01, 1'b0, 9'h080},
        '{8'hFF, 8'hFF, 1'b1, 9'h1FF},
        '{8'h12, 8'h34, 1'b1, 9'h047}
    };

    initial begin
        int busy_n;
        int done_at;
        int n;
        rst_n  = 1'b0;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start8 = 1'b0;
        a8     = '0;
        b8     = '0;
        cin8   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_sum", sum, 4'h0);
        check("rst_cout", cout, 1'b0);
        check("rst_busy8", busy8, 1'b0);
        check("rst_sum8", {cout8, sum8}, 9'h000);
        rst_n = 1'b1;
        @(negedge clk);

        // 1) timing: busy for 5 cycles, done on the 5th busy cycle
        issue4(4'b0011, 4'b0101, 1'b0, 5'b01000, 1'b1);
        busy_n  = 0;
        done_at = 0;
        n       = 0;
        while (busy === 1'b1 && n < 20) begin
            busy_n++;
            if (done === 1'b1) done_at = busy_n;
            @(negedge clk);
            n++;
        end
        check("busy_cycles", busy_n, 5);
        check("done_position", done_at, 5);

        // 2) overflow cases
        issue4(4'b1111, 4'b0001, 1'b0, 5'b10000, 1'b1);
        issue4(4'b1111, 4'b1111, 1'b1, 5'b11111, 1'b1);

        // 3) start held high: a new op every 6 cycles
        wait_idle4();
        done_cyc.delete();
        a     = 4'b0001;
        b     = 4'b0001;
        cin   = 1'b0;
        start = 1'b1;
        repeat (3) exp_q.push_back(5'b00010);
        n = 0;
        while (done_cyc.size() < 3 && n < 40) begin
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (done_cyc.size() >= 3) begin
            check("period_1", done_cyc[1] - done_cyc[0], 6);
            check("period_2", done_cyc[2] - done_cyc[1], 6);
        end else begin
            check("held_start_dones", done_cyc.size(), 3);
        end

        // 4) start and operand changes during RUN are ignored
        issue4(4'b0011, 4'b0101, 1'b1, 5'b01001, 1'b1);
        a     = 4'b1111;
        b     = 4'b1110;
        cin   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        a     = 4'b0110;
        @(negedge clk);
        start = 1'b0;
        wait_idle4();

        // 5) asynchronous reset mid-RUN
        issue4(4'b1010, 4'b0111, 1'b1, 5'b0, 1'b0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_done", done, 1'b0);
        check("arst_sum", sum, 4'h0);
        check("arst_cout", cout, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue4(4'b1010, 4'b0111, 1'b1, 5'b10010, 1'b1);

        // 6) WIDTH=8 directed vectors on the second instance
        for (int i = 0; i < 8; i++) issue8(v8[i].a, v8[i].b, v8[i].c, v8[i].r);

        // full WIDTH=4 sweep against a + b + cin
        for (int ai = 0; ai < 16; ai++)
            for (int bi = 0; bi < 16; bi++)
                for (int ci = 0; ci < 2; ci++)
                    issue4(4'(ai), 4'(bi), 1'(ci), 5'(ai + bi + ci), 1'b1);

        drain();
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
